// File: rtl/hack_rom_loader_pkg.sv
// Shared types and constants for the ROM loader receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hack_rom_loader_pkg;

    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam int         FRAME_BITS    = 48;
    localparam int         SRAM_ADDR_BITS = 24;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        CS_HIGH
    } state_t;

    // One 23LC1024 WRITE transaction: command, 24-bit byte address, one 16-bit word.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [SRAM_ADDR_BITS-1:0] byte_addr,
        input logic [15:0]               data
    );
        return {SPI_CMD_WRITE, byte_addr, data};
    endfunction

endpackage

// File: rtl/hack_rom_loader_rx_spi_frame_tx.sv
// Serialises one 48-bit frame MSB first as SPI mode 0 at clk/2.
// Latency: 2 cycles per bit, 96 cycles per frame; o_last flags the final cycle.
// Backpressure: none; the caller holds i_shift_en for the whole frame.
module spi_frame_tx
    import hack_rom_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [FRAME_BITS-1:0] i_frame,
    input  logic                  i_shift_en,
    output logic                  o_sck,
    output logic                  o_si,
    output logic                  o_last
);

    localparam int CNT_W = $clog2(FRAME_BITS);

    logic [FRAME_BITS-1:0] r_shreg;
    logic                  r_phase;
    logic [CNT_W-1:0]      r_bit_cnt;

    // Low phase then high phase per bit; SI advances on the high->low step only.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_shreg   <= '0;
            r_phase   <= 1'b0;
            r_bit_cnt <= '0;
        end else if (i_load) begin
            r_shreg   <= i_frame;
            r_phase   <= 1'b0;
            r_bit_cnt <= '0;
        end else if (i_shift_en) begin
            if (!r_phase) begin
                r_phase <= 1'b1;
            end else begin
                r_phase   <= 1'b0;
                r_shreg   <= {r_shreg[FRAME_BITS-2:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign o_sck  = r_phase;
    assign o_si   = r_shreg[FRAME_BITS-1];
    assign o_last = i_shift_en & r_phase & (r_bit_cnt == CNT_W'(FRAME_BITS - 1));

endmodule

// File: rtl/hack_rom_loader_rx.sv
// Accepts 16-bit instruction words by load/ack handshake and writes each to serial SRAM.
// Latency: 1+1+96+1+CS_HIGH_CYCLES cycles from accepted load to ack high again.
// Backpressure: ack low while a frame is in flight; a held load needs a low phase before re-accept.
module hack_rom_loader_rx
    import hack_rom_loader_pkg::*;
#(
    parameter int WORD_ADDR_WIDTH = 16,
    parameter int CS_HIGH_CYCLES  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rom_loader_reset,
    input  logic                       rom_loader_load,
    input  logic [15:0]                rom_loader_data,
    output logic                       rom_loader_ack,
    output logic                       rom_loader_load_received,
    output logic                       busy,
    output logic [WORD_ADDR_WIDTH-1:0] word_addr,
    output logic                       sram_cs_n,
    output logic                       sram_sck,
    output logic                       sram_sio_oe,
    output logic [3:0]                 sram_sio_o
);

    localparam int HI_W = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        r_seen_low;
    logic                        r_load_received;
    logic [WORD_ADDR_WIDTH-1:0]  r_word_addr;
    logic [HI_W-1:0]             r_hi_cnt;

    logic                        w_clear;
    logic                        w_accept;
    logic                        w_shift_en;
    logic                        w_last;
    logic                        w_sck;
    logic                        w_si;
    logic [SRAM_ADDR_BITS-1:0]   w_byte_addr;
    logic [FRAME_BITS-1:0]       w_frame;

    // Either reset abandons the frame; only the system reset also clears the load history.
    assign w_clear     = reset | rom_loader_reset;
    assign w_accept    = (r_state == IDLE) & rom_loader_load & r_seen_low & ~w_clear;
    assign w_shift_en  = (r_state == SHIFT);
    assign w_byte_addr = SRAM_ADDR_BITS'(r_word_addr) << 1;
    assign w_frame     = build_frame(w_byte_addr, rom_loader_data);

    // State register; both resets land in IDLE.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and SRAM pin/handshake decode.
    always_comb begin
        w_state_nxt    = r_state;
        rom_loader_ack = 1'b0;
        busy           = 1'b1;
        sram_cs_n      = 1'b0;
        sram_sio_oe    = 1'b1;
        case (r_state)
            IDLE: begin
                rom_loader_ack = ~reset;
                busy           = 1'b0;
                sram_cs_n      = 1'b1;
                sram_sio_oe    = 1'b0;
                if (w_accept) begin
                    w_state_nxt = CS_SETUP;
                end
            end
            CS_SETUP: w_state_nxt = SHIFT;
            SHIFT: begin
                if (w_last) begin
                    w_state_nxt = CS_HOLD;
                end
            end
            CS_HOLD: w_state_nxt = CS_HIGH;
            CS_HIGH: begin
                sram_cs_n   = 1'b1;
                sram_sio_oe = 1'b0;
                if (r_hi_cnt == HI_W'(CS_HIGH_CYCLES - 1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counts the cs_n high gap between frames.
    always_ff @(posedge clk) begin
        if (w_clear || r_state != CS_HIGH) begin
            r_hi_cnt <= '0;
        end else begin
            r_hi_cnt <= r_hi_cnt + 1'b1;
        end
    end

    // Next-word address; advances as the frame closes and wraps at the ROM depth.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_word_addr <= '0;
        end else if (r_state == CS_HOLD) begin
            r_word_addr <= r_word_addr + 1'b1;
        end
    end

    // Receipt pulse and the "load seen low" edge qualifier that blocks repeat writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen_low      <= 1'b0;
            r_load_received <= 1'b0;
        end else begin
            r_load_received <= w_accept;
            if (!rom_loader_reset) begin
                if (w_accept) begin
                    r_seen_low <= 1'b0;
                end else if (!rom_loader_load) begin
                    r_seen_low <= 1'b1;
                end
            end
        end
    end

    spi_frame_tx u_spi_frame_tx (
        .clk        (clk),
        .i_clear    (w_clear),
        .i_load     (w_accept),
        .i_frame    (w_frame),
        .i_shift_en (w_shift_en),
        .o_sck      (w_sck),
        .o_si       (w_si),
        .o_last     (w_last)
    );

    assign rom_loader_load_received = r_load_received;
    assign word_addr                = r_word_addr;
    assign sram_sck                 = w_sck;
    assign sram_sio_o               = {1'b1, 2'b00, w_si};

endmodule
